// File: rtl/train_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : train_sequencer
// Brief    : Qualifies the four-way permit, sounds the departure bell, runs
//            the motor, and brakes on stop or on permit loss (latching a fault).
// Revision : 1.0 - initial release
// ============================================================================
module train_sequencer #(
    parameter int CHECK_CYCLES = 4,
    parameter int WARN_CYCLES  = 8,
    parameter int BRAKE_CYCLES = 6,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       A,
    input  logic       B,
    input  logic       C,
    input  logic       D,
    output logic       motor_en,
    output logic       brake,
    output logic       bell,
    output logic       fault,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_WARN  = 3'd2,
        S_RUN   = 3'd3,
        S_BRAKE = 3'd4,
        S_FAULT = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] c_check_last = CNT_W'(CHECK_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_warn_last  = CNT_W'(WARN_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_brake_last = CNT_W'(BRAKE_CYCLES - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_flt_pend;
    logic             w_flt_pend_nxt;
    logic             w_permit;

    assign w_permit = A & B & C & D;
    assign state    = r_state;

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_flt_pend_nxt = r_flt_pend;
        case (r_state)
            S_IDLE: begin
                if (!stop && start) w_state_nxt = S_CHECK;
            end
            S_CHECK: begin
                if (stop)                       w_state_nxt = S_IDLE;
                else if (!w_permit)             w_cnt_nxt   = '0;
                else if (r_cnt == c_check_last) w_state_nxt = S_WARN;
                else                            w_cnt_nxt   = r_cnt + CNT_W'(1);
            end
            S_WARN: begin
                if (stop)                      w_state_nxt = S_IDLE;
                else if (!w_permit)            w_state_nxt = S_CHECK;
                else if (r_cnt == c_warn_last) w_state_nxt = S_RUN;
                else                           w_cnt_nxt   = r_cnt + CNT_W'(1);
            end
            S_RUN: begin
                // Permit loss outranks a simultaneous stop so the fault is not lost.
                if (!w_permit) begin
                    w_state_nxt    = S_BRAKE;
                    w_flt_pend_nxt = 1'b1;
                end else if (stop) begin
                    w_state_nxt    = S_BRAKE;
                    w_flt_pend_nxt = 1'b0;
                end
            end
            S_BRAKE: begin
                if (r_cnt == c_brake_last) w_state_nxt = r_flt_pend ? S_FAULT : S_IDLE;
                else                       w_cnt_nxt   = r_cnt + CNT_W'(1);
            end
            S_FAULT: begin
                if (stop && w_permit) begin
                    w_state_nxt    = S_IDLE;
                    w_flt_pend_nxt = 1'b0;
                end
            end
            default: w_state_nxt = S_FAULT;
        endcase
        // The counter always starts from zero in a freshly entered state.
        if (w_state_nxt != r_state) w_cnt_nxt = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_flt_pend <= 1'b0;
            motor_en   <= 1'b0;
            brake      <= 1'b1;
            bell       <= 1'b0;
            fault      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_flt_pend <= w_flt_pend_nxt;
            // Outputs are a registered decode of the current state, so they
            // trail the state register by one cycle and never see inputs directly.
            motor_en   <= (r_state == S_RUN);
            brake      <= (r_state != S_RUN);
            bell       <= (r_state == S_WARN);
            fault      <= (r_state == S_FAULT);
        end
    end

endmodule
`default_nettype wire
